// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp patterns for the two-road phase arbiter.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_AG = 2'd0,
        PH_AY = 2'd1,
        PH_BG = 2'd2,
        PH_BY = 2'd3
    } phase_e;

    // Lamp order: {A_red, A_yel, A_grn, B_red, B_yel, B_grn}
    localparam logic [5:0] LED_AG = 6'b001_100;
    localparam logic [5:0] LED_AY = 6'b010_100;
    localparam logic [5:0] LED_BG = 6'b100_001;
    localparam logic [5:0] LED_BY = 6'b100_010;

endpackage

// File: rtl/sensor_latch.sv
// Car-sensor front end: two-flop synchronizer feeding a sticky request flop.
module sensor_latch (
    input  logic clk,
    input  logic rst,
    input  logic sensor,
    input  logic block,
    input  logic clear,
    output logic req
);

    logic sync1_q, sync2_q;
    logic req_q, req_d;

    // Clear wins over a same-cycle sensor hit so the entering green starts clean.
    always_comb begin
        req_d = req_q;
        if (clear)
            req_d = 1'b0;
        else if (sync2_q && !block)
            req_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            sync1_q <= sensor;
            sync2_q <= sync1_q;
            req_q   <= req_d;
        end
    end

    assign req = req_q;

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Sensor-driven green/yellow/red sequencer for roads A and B with per-road
// remaining-seconds outputs for the display path.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int GREEN_A = 25,
    parameter int GREEN_B = 20,
    parameter int YELLOW  = 5
) (
    input  logic       clk_50M,
    input  logic       reset_btn,
    input  logic       tick_1hz,
    input  logic       AS,
    input  logic       BS,
    output logic [1:0] state,
    output logic [5:0] led,
    output logic [5:0] A_time,
    output logic [5:0] B_time
);

    localparam logic [5:0] GA6  = 6'(GREEN_A);
    localparam logic [5:0] GB6  = 6'(GREEN_B);
    localparam logic [5:0] YEL6 = 6'(YELLOW);

    phase_e     phase_q, phase_d;
    logic [5:0] cnt_q, cnt_d;
    logic       req_a, req_b;
    logic       clear_a, clear_b;

    sensor_latch u_lat_a (
        .clk    (clk_50M),
        .rst    (reset_btn),
        .sensor (AS),
        .block  (phase_q == PH_AG),
        .clear  (clear_a),
        .req    (req_a)
    );

    sensor_latch u_lat_b (
        .clk    (clk_50M),
        .rst    (reset_btn),
        .sensor (BS),
        .block  (phase_q == PH_BG),
        .clear  (clear_b),
        .req    (req_b)
    );

    // Count down on ticks; at expiry either hand over or reload the same green.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (tick_1hz) begin
            if (cnt_q > 6'd1) begin
                cnt_d = cnt_q - 6'd1;
            end else begin
                unique case (phase_q)
                    PH_AG: begin
                        if (req_b) begin
                            phase_d = PH_AY;
                            cnt_d   = YEL6;
                        end else begin
                            cnt_d   = GA6;
                        end
                    end
                    PH_AY: begin
                        phase_d = PH_BG;
                        cnt_d   = GB6;
                    end
                    PH_BG: begin
                        if (req_a) begin
                            phase_d = PH_BY;
                            cnt_d   = YEL6;
                        end else begin
                            cnt_d   = GB6;
                        end
                    end
                    PH_BY: begin
                        phase_d = PH_AG;
                        cnt_d   = GA6;
                    end
                    default: begin
                        phase_d = PH_AG;
                        cnt_d   = GA6;
                    end
                endcase
            end
        end
    end

    assign clear_a = (phase_q == PH_BY) && (phase_d == PH_AG);
    assign clear_b = (phase_q == PH_AY) && (phase_d == PH_BG);

    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            phase_q <= PH_AG;
            cnt_q   <= GA6;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // The road still waiting behind a green also sits through the yellow.
    always_comb begin
        state  = phase_q;
        led    = LED_AG;
        A_time = cnt_q;
        B_time = cnt_q;
        unique case (phase_q)
            PH_AG: begin
                led    = LED_AG;
                B_time = cnt_q + YEL6;
            end
            PH_AY: led = LED_AY;
            PH_BG: begin
                led    = LED_BG;
                A_time = cnt_q + YEL6;
            end
            PH_BY: led = LED_BY;
            default: led = LED_AG;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed table-driven bench for traffic_phase_arbiter plus multi-cycle corner
// sequences and a randomized lamp/time invariant run.
module tb_traffic_phase_arbiter;

    logic       clk_50M = 1'b0;
    logic       reset_btn, tick_1hz, AS, BS;
    logic [1:0] state;
    logic [5:0] led, A_time, B_time;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    traffic_phase_arbiter #(.GREEN_A(25), .GREEN_B(20), .YELLOW(5)) dut (
        .clk_50M   (clk_50M),
        .reset_btn (reset_btn),
        .tick_1hz  (tick_1hz),
        .AS        (AS),
        .BS        (BS),
        .state     (state),
        .led       (led),
        .A_time    (A_time),
        .B_time    (B_time)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic       as_v;
        logic       bs_v;
        int         ticks;
        logic [1:0] st;
        logic [5:0] ld;
        logic [5:0] at;
        logic [5:0] bt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [5:0] ld,
                           input logic [5:0] at, input logic [5:0] bt);
        chk({tag, ".state"}, {4'd0, state}, {4'd0, st});
        chk({tag, ".led"}, led, ld);
        chk({tag, ".A_time"}, A_time, at);
        chk({tag, ".B_time"}, B_time, bt);
    endtask

    // Called at a negedge; returns at a negedge with tick low.
    task automatic do_ticks(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            @(negedge clk_50M);
            tick_1hz = 1'b0;
            @(negedge clk_50M);
        end
    endtask

    // Invariants sampled mid-cycle during the randomized run.
    always @(negedge clk_50M) begin
        if (mon_en) begin
            checks++;
            if (!(led == 6'b001100 || led == 6'b010100 || led == 6'b100001 || led == 6'b100010)) begin
                errors++;
                $display("FAIL inv.led actual=%b required=one of 4 patterns", led);
            end
            checks++;
            if (led[3] && led[0]) begin
                errors++;
                $display("FAIL inv.both_green actual=%b required=not both greens", led);
            end
            checks++;
            if (A_time < 6'd1 || B_time < 6'd1 || A_time > 6'd30 || B_time > 6'd30) begin
                errors++;
                $display("FAIL inv.time_range actual=A%0d/B%0d required=1..30", A_time, B_time);
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0,  0, 2'd0, 6'b001100, 6'd25, 6'd30};
        vecs[1]  = '{1'b0, 1'b0, 24, 2'd0, 6'b001100, 6'd1,  6'd6 };
        vecs[2]  = '{1'b0, 1'b0,  1, 2'd0, 6'b001100, 6'd25, 6'd30};
        vecs[3]  = '{1'b0, 1'b0,  5, 2'd0, 6'b001100, 6'd20, 6'd25};
        vecs[4]  = '{1'b0, 1'b1,  1, 2'd0, 6'b001100, 6'd19, 6'd24};
        vecs[5]  = '{1'b0, 1'b0, 18, 2'd0, 6'b001100, 6'd1,  6'd6 };
        vecs[6]  = '{1'b0, 1'b0,  1, 2'd1, 6'b010100, 6'd5,  6'd5 };
        vecs[7]  = '{1'b0, 1'b0,  4, 2'd1, 6'b010100, 6'd1,  6'd1 };
        vecs[8]  = '{1'b0, 1'b0,  1, 2'd2, 6'b100001, 6'd25, 6'd20};
        vecs[9]  = '{1'b0, 1'b1, 19, 2'd2, 6'b100001, 6'd6,  6'd1 };
        vecs[10] = '{1'b0, 1'b1,  1, 2'd2, 6'b100001, 6'd25, 6'd20};
        vecs[11] = '{1'b1, 1'b1,  5, 2'd2, 6'b100001, 6'd20, 6'd15};
        vecs[12] = '{1'b0, 1'b0, 14, 2'd2, 6'b100001, 6'd6,  6'd1 };
        vecs[13] = '{1'b0, 1'b0,  1, 2'd3, 6'b100010, 6'd5,  6'd5 };
        vecs[14] = '{1'b0, 1'b0,  5, 2'd0, 6'b001100, 6'd25, 6'd30};
        vecs[15] = '{1'b0, 1'b0, 25, 2'd0, 6'b001100, 6'd25, 6'd30};

        // Clock/reset
        tick_1hz  = 1'b0;
        AS        = 1'b0;
        BS        = 1'b0;
        reset_btn = 1'b1;
        #3;
        chk_all("reset_async", 2'd0, 6'b001100, 6'd25, 6'd30);
        repeat (3) @(negedge clk_50M);
        reset_btn = 1'b0;
        @(negedge clk_50M);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            AS = vecs[i].as_v;
            BS = vecs[i].bs_v;
            repeat (3) @(negedge clk_50M);
            do_ticks(vecs[i].ticks);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ld, vecs[i].at, vecs[i].bt);
        end

        // BS becomes synchronized exactly on the AG expiry tick: stays AG, acts next expiry.
        do_ticks(24);
        chk_all("sameclk.pre", 2'd0, 6'b001100, 6'd1, 6'd6);
        BS = 1'b1;
        @(negedge clk_50M);
        @(negedge clk_50M);
        tick_1hz = 1'b1;
        @(negedge clk_50M);
        tick_1hz = 1'b0;
        BS = 1'b0;
        @(negedge clk_50M);
        chk_all("sameclk.hold", 2'd0, 6'b001100, 6'd25, 6'd30);
        do_ticks(24);
        chk_all("sameclk.cnt1", 2'd0, 6'b001100, 6'd1, 6'd6);
        do_ticks(1);
        chk_all("sameclk.ay", 2'd1, 6'b010100, 6'd5, 6'd5);

        // Asynchronous reset in AY with cnt = 3, then ticks ignored while held.
        do_ticks(2);
        chk_all("ay.cnt3", 2'd1, 6'b010100, 6'd3, 6'd3);
        #2;
        reset_btn = 1'b1;
        #1;
        chk_all("reset_mid_ay", 2'd0, 6'b001100, 6'd25, 6'd30);
        @(negedge clk_50M);
        tick_1hz = 1'b1;
        @(negedge clk_50M);
        tick_1hz = 1'b0;
        reset_btn = 1'b0;
        @(negedge clk_50M);
        chk_all("reset_tick_ignored", 2'd0, 6'b001100, 6'd25, 6'd30);

        // Randomized run with invariants checked every cycle.
        mon_en = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            AS = 1'($urandom_range(0, 1));
            BS = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk_50M);
            do_ticks(1);
        end
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
- Sensor-driven phase controller for the two-road intersection. It shares right-of-way between road A and road B, driven by the AS/BS car-sensor requests.
- It sequences green, yellow and red, and produces the 2-bit state code, the 6 lamp bits and the per-road remaining-seconds values.
- Its outputs feed the LCD display path unchanged (A_time/B_time, then tens/units split downstream).
- It runs on the 50 MHz clock with a 1 Hz tick enable from the existing divider.

Parameters:
- GREEN_A, 25, A green duration in seconds (1..58)
- GREEN_B, 20, B green duration in seconds (1..58)
- YELLOW, 5, yellow duration in seconds (1..5). GREEN_x+YELLOW must be ≤ 63.

Ports:
- clk_50M  input  1  system clock
- reset_btn  input  1  asynchronous, active-high reset
- tick_1hz  input  1  one-cycle enable pulse, once per second, synchronous to clk_50M
- AS  input  1  road A car sensor, asynchronous level, high = car waiting
- BS  input  1  road B car sensor, asynchronous level, high = car waiting
- state  output  2  phase code: 0 = AG, 1 = AY, 2 = BG, 3 = BY
- led  output  6  {A_red, A_yel, A_grn, B_red, B_yel, B_grn}
- A_time  output  6  seconds until A's lamp next changes
- B_time  output  6  seconds until B's lamp next changes

Behaviour:
- Reset (reset_btn high, any time, asynchronous):
  - phase AG, cnt = GREEN_A, req_a = req_b = 0, synchronizers cleared.
  - Outputs: state = 0, led = 6'b001_100, A_time = GREEN_A, B_time = GREEN_A+YELLOW.
  - Reset asserted mid-phase abandons that phase immediately.
- Sensors:
  - AS and BS each pass through a 2-flop synchronizer.
  - A synchronized high sets sticky req_a / req_b respectively.
  - A request for the road currently green (AG/AG for A, BG for B) is not latched.
  - req_x is cleared on the edge that enters X's green.
- Counter: cnt is 6 bits and only changes on cycles where tick_1hz = 1. When cnt > 1 it decrements by 1.
- Expiry (tick_1hz = 1 and cnt == 1):
  - AG: if req_b = 1, go to AY with cnt = YELLOW. Otherwise stay in AG with cnt = GREEN_A (A holds green indefinitely while B is idle).
  - AY: go to BG with cnt = GREEN_B; clear req_b.
  - BG: if req_a = 1, go to BY with cnt = YELLOW. Otherwise reload cnt = GREEN_B and stay.
  - BY: go to AG with cnt = GREEN_A; clear req_a.
- The expiry decision uses the registered req value. A request synchronized on the same cycle as the expiry tick is latched, but acts only at the next expiry.
- Ticks are ignored entirely while reset is asserted. No ticks means the phase freezes.
- Output decode is combinational from the phase and cnt registers only. Outputs change on the same edge as the registers; no extra latency.
- led per phase:
  - AG = 001_100
  - AY = 010_100
  - BG = 100_001
  - BY = 100_010
- Time outputs:
  - AG: A_time = cnt, B_time = cnt+YELLOW
  - AY: A_time = cnt, B_time = cnt
  - BG: A_time = cnt+YELLOW, B_time = cnt
  - BY: A_time = cnt, B_time = cnt
- Additions are 6-bit and cannot overflow given the parameter limits.
- Exactly one lamp per road is lit in every phase. Both greens are never lit together.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings PH_AG/PH_AY/PH_BG/PH_BY (2-bit)
  - led pattern constants LED_AG/LED_AY/LED_BG/LED_BY
- One sub-module, sensor_latch, instantiated twice. It contains the 2-flop synchronizer, the sticky request flop, a block input that suppresses latching while its road is green, and a clear input.

Test Plan:
- Reset, then 30 ticks with AS = BS = 0 → stays AG throughout. A_time runs 25→1, then reloads to 25 on the 25th tick. state = 0 and led = 001100 constant.
- Pulse BS high for 3 cycles at tick 3 → req_b set. At the 25th tick the block enters AY with A_time = B_time = 5. Five ticks later it enters BG with B_time = 20, A_time = 25, led = 100001.
- While in BG, pulse AS → after B's remaining count it enters BY and then AG with cnt = 25. Hold BS high throughout BG → no req_b is latched, and AG is entered once.
- BS rises on the same clock as the AG expiry tick → block stays AG with cnt = 25. Transition to AY occurs at the next expiry, 25 ticks later.
- Assert reset_btn during AY with cnt = 3 → outputs return asynchronously to state = 0, led = 001100, A_time = 25, B_time = 30 before the next clock edge.
- Over a randomized 2000-tick run, assert every cycle: no led value outside the 4 patterns, A_grn & B_grn never both set, and A_time, B_time ≥ 1.
